// File: rtl/parity_fifo_pkg.sv
// Shared widths and types for parity_fifo and its storage.
package fifo_package;

    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [$clog2(FIFO_DEPTH)-1:0] ptr_t;
    typedef logic [$clog2(FIFO_DEPTH+1)-1:0] cnt_t;

endpackage

// File: rtl/parity_fifo_mem.sv
// fifo_mem: register array with one synchronous write port and one
// asynchronous read port; contents are never reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/parity_fifo.sv
// parity_fifo: first-word-fall-through FIFO in front of parity_check.
// Define PARITY_FIFO_PARITY_EN to store an even-parity bit with each word.
module parity_fifo
    import fifo_package::*;
#(
    parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         grant_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         parity_o,
    output logic                         valid_o,
    input  logic                         grant_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
`ifdef PARITY_FIFO_PARITY_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [EW-1:0] wdata, rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status decodes only from the count register: no input-to-output path.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign grant_o = !full_o;
    assign valid_o = !empty_o;
    assign count_o = count_q;

    assign push = valid_i && grant_o;
    assign pop  = valid_o && grant_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef PARITY_FIFO_PARITY_EN
    assign wdata    = {^data_i, data_i};
    assign parity_o = valid_o & rdata[DATA_WIDTH];
`else
    assign wdata    = data_i;
    assign parity_o = 1'b0;
`endif

    assign data_o = valid_o ? rdata[DATA_WIDTH-1:0] : '0;

    fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_parity_fifo.sv
// Directed bench for parity_fifo with hand-computed expectations.
module tb_parity_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic       grant_o;
    logic [7:0] data_o;
    logic       parity_o;
    logic       valid_o;
    logic       grant_i;
    logic [3:0] count_o;
    logic       full_o;
    logic       empty_o;

    int n_vec = 0;
    int n_err = 0;

    parity_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .grant_o  (grant_o),
        .data_o   (data_o),
        .parity_o (parity_o),
        .valid_o  (valid_o),
        .grant_i  (grant_i),
        .count_o  (count_o),
        .full_o   (full_o),
        .empty_o  (empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic par(input logic [7:0] d);
`ifdef PARITY_FIFO_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"},  valid_o,  0);
        chk({tag, "_grant"},  grant_o,  1);
        chk({tag, "_full"},   full_o,   0);
        chk({tag, "_empty"},  empty_o,  1);
        chk({tag, "_count"},  count_o,  0);
        chk({tag, "_data"},   data_o,   0);
        chk({tag, "_parity"}, parity_o, 0);
    endtask

    initial begin
        rst     = 1'b1;
        data_i  = '0;
        valid_i = 1'b0;
        grant_i = 1'b0;
        #12;
        chk_reset_state("rst");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full with downstream stalled.
        for (int i = 1; i <= 8; i++) begin
            data_i  = 8'(i);
            valid_i = 1'b1;
            tick();
            if (i == 1) begin
                chk("lat_valid", valid_o, 1);
                chk("lat_data", data_o, 8'h01);
            end
        end
        chk("fill_full", full_o, 1);
        chk("fill_grant", grant_o, 0);
        chk("fill_count", count_o, 8);
        data_i = 8'hFF;
        tick();
        chk("ovf_count", count_o, 8);
        chk("ovf_head", data_o, 8'h01);

        // Drain in order.
        valid_i = 1'b0;
        grant_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", data_o, 32'(i));
            chk("drain_par", parity_o, 32'(par(8'(i))));
            tick();
        end
        chk("drain_empty", empty_o, 1);
        chk("drain_valid", valid_o, 0);
        chk("drain_zero", data_o, 0);
        chk("drain_count", count_o, 0);

        // Streaming with simultaneous push and pop across the wrap.
        valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_i = 8'(8'h10 + k);
            if (k > 0) chk("stream_data", data_o, 32'(8'h10 + k - 1));
            tick();
            chk("stream_count", count_o, 1);
        end
        valid_i = 1'b0;
        chk("stream_last", data_o, 8'h23);
        tick();
        chk("stream_empty", empty_o, 1);

        // Full with push and pop together: pop only, then push next cycle.
        grant_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_i = 8'(8'h30 + i);
            tick();
        end
        chk("fp_full", full_o, 1);
        data_i  = 8'h40;
        grant_i = 1'b1;
        tick();
        chk("fp_count7", count_o, 7);
        chk("fp_head", data_o, 8'h31);
        grant_i = 1'b0;
        tick();
        chk("fp_count8", count_o, 8);
        valid_i = 1'b0;
        grant_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("fp_drain", data_o, (i == 8) ? 32'h40 : 32'(8'h30 + i));
            tick();
        end
        chk("fp_empty", empty_o, 1);

        // Asynchronous reset mid-stream.
        grant_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = 8'(8'h50 + i);
            tick();
        end
        chk("mid_count5", count_o, 5);
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("mid");
        @(negedge clk);
        rst     = 1'b0;
        data_i  = 8'hAA;
        valid_i = 1'b1;
        tick();
        data_i = 8'hBB;
        tick();
        valid_i = 1'b0;
        chk("post_count", count_o, 2);
        chk("post_head", data_o, 8'hAA);
        grant_i = 1'b1;
        tick();
        chk("post_second", data_o, 8'hBB);
        tick();
        chk("post_empty", empty_o, 1);

        // Parity of head entry.
        grant_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h03;
        tick();
        data_i = 8'h07;
        tick();
        valid_i = 1'b0;
        chk("par_03", parity_o, 32'(par(8'h03)));
        grant_i = 1'b1;
        tick();
        chk("par_07", parity_o, 32'(par(8'h07)));
        tick();
        chk("par_empty", parity_o, 0);
        grant_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parity_fifo.md
# parity_fifo

Synchronous FIFO buffering data words in front of `parity_check`. It accepts words on a valid/grant handshake and stores them in a circular buffer. Words are presented first-word-fall-through on a matching valid/grant output handshake that connects directly to `parity_check` inputs. Optionally, an even-parity bit is computed at write time and travels with each word.

## Interface
Parameters:
- `DATA_WIDTH`, default from `fifo_package`, payload width in bits.
- `DEPTH`, default `FIFO_DEPTH` (8), number of entries, ≥2; need not be a power of two.

Ports:
- `clk` in 1: the single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_i` in DATA_WIDTH: write data.
- `valid_i` in 1: upstream offers `data_i`.
- `grant_o` out 1: FIFO can accept (not full).
- `data_o` out DATA_WIDTH: head-of-queue word.
- `parity_o` out 1: stored parity of head word (see Configuration).
- `valid_o` out 1: head word available (not empty).
- `grant_i` in 1: downstream (`parity_check`) accepts head word.
- `count_o` out $clog2(DEPTH+1): current occupancy.
- `full_o` out 1: count == DEPTH.
- `empty_o` out 1: count == 0.

## Operation
- Push: `valid_i && grant_o` at an edge writes `data_i` at `wr_ptr`, then advances `wr_ptr`.
- Pop: `valid_o && grant_i` at an edge advances `rd_ptr`.
- Pointers range 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
- `count` is a register:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- `grant_o = !full_o`, `valid_o = !empty_o`. Both are decoded from the `count` register only, never from `valid_i` or `grant_i` (no combinational path input→output).
- When full, `grant_o` = 0, so no push occurs even if a pop happens in the same cycle. The freed slot becomes available in the following cycle.
- When empty, `valid_o` = 0, so no pop occurs. A push to an empty FIFO is not bypassed.
- `data_o` = storage[`rd_ptr`] while `valid_o` = 1, and is forced to 0 while empty.
- `data_o` holds its value until popped; protocol stability is guaranteed while `valid_o && !grant_i`.
- Upstream may drop `valid_i` at any time. No transfer occurs without grant.
- Storage array is not reset; only pointers and count are reset.

## Timing
- Reset (async assert, any cycle, including mid-transfer):
  - `wr_ptr` = `rd_ptr` = `count` = 0.
  - `valid_o` = 0, `grant_o` = 1, `full_o` = 0, `empty_o` = 1, `count_o` = 0, `data_o` = 0, `parity_o` = 0.
  - Stored contents are discarded.
- Deassertion takes effect on the next rising edge; the first push can occur at that edge.
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible on `data_o` with `valid_o` = 1 after edge N.
- Throughput is 1 word/cycle when neither full nor empty.
- Status outputs update at the same edge as the push or pop that causes them.

## Configuration
- `PARITY_FIFO_PARITY_EN` defined:
  - Each entry is DATA_WIDTH+1 bits wide.
  - At push, `^data_i` (even parity: the XOR of all data bits) is stored alongside the data.
  - `parity_o` outputs the head entry's parity bit, or 0 when empty.
- `PARITY_FIFO_PARITY_EN` undefined:
  - Entries are DATA_WIDTH bits wide.
  - `parity_o` is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- `fifo_package` holds:
  - `DATA_WIDTH` and `FIFO_DEPTH`.
  - `typedef logic [DATA_WIDTH-1:0] data_t`.
  - `typedef logic [$clog2(FIFO_DEPTH)-1:0] ptr_t`.
  - `typedef logic [$clog2(FIFO_DEPTH+1)-1:0] cnt_t`.
- Sub-module `fifo_mem`:
  - Parameterised width/depth register array.
  - One synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`).
  - Handles storage only.
- Pointer, count and handshake logic stays in `parity_fifo`.

## Test plan
- Reset, then push 0x01..0x08 (DEPTH=8) with `grant_i` = 0:
  - `full_o` = 1, `grant_o` = 0, `count_o` = 8.
  - A 9th `valid_i` with 0xFF is not stored.
- Then hold `grant_i` = 1: outputs 0x01..0x08 in order on consecutive cycles, then `empty_o` = 1, `valid_o` = 0, `data_o` = 0.
- Continuous `valid_i` and `grant_i` for 20 words (0x10..0x23):
  - Wrap-around is exercised and the data order is preserved.
  - `count_o` stays at 1 after the first cycle.
- At full, assert `valid_i` and `grant_i` together: a pop occurs, no push, `count_o` = 7. On the next cycle, the push is accepted.
- Assert `rst` mid-stream with `count_o` = 5: outputs immediately return to their reset values. After release, the first pushed word 0xAA is the first output.
- With `PARITY_FIFO_PARITY_EN`: push 0x03 then 0x07 → `parity_o` = 0, then 1. Without the macro, `parity_o` is always 0.
